// File: rtl/riscv_dmem_responder_pkg.sv
// Shared types for the data-memory responder:
// response entry layout, request kinds, accept FSM states.
package riscv_dmem_responder_pkg;

  localparam int TAG_W  = 11;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_MEM,
    REQ_CMO
  } req_kind_e;

  typedef enum logic [1:0] {
    ACC_READY,
    ACC_GAP,
    ACC_FULL
  } acc_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  // Loads/stores win over cache ops raised in the same cycle.
  function automatic req_kind_e req_kind(
    input logic       rd,
    input logic [3:0] wr,
    input logic       cmo
  );
    req_kind_e k;
    logic      mem;
    mem = rd | (|wr);
    unique case (1'b1)
      mem:         k = REQ_MEM;
      cmo && !mem: k = REQ_CMO;
      default:     k = REQ_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// mem_d_* request/response bundle between core and data memory.
// master = core side, slave = memory responder side.
interface riscv_dmem_responder_if;

  logic [31:0] mem_d_addr_i;
  logic [31:0] mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic        mem_d_cacheable_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_invalidate_i;
  logic        mem_d_writeback_i;
  logic        mem_d_flush_i;
  logic        mem_d_accept_o;
  logic        mem_d_ack_o;
  logic        mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;
  logic [31:0] mem_d_data_rd_o;

  modport master (
    output mem_d_addr_i, mem_d_data_wr_i,
    output mem_d_rd_i, mem_d_wr_i,
    output mem_d_cacheable_i, mem_d_req_tag_i,
    output mem_d_invalidate_i,
    output mem_d_writeback_i, mem_d_flush_i,
    input  mem_d_accept_o, mem_d_ack_o,
    input  mem_d_error_o, mem_d_resp_tag_o,
    input  mem_d_data_rd_o
  );

  modport slave (
    input  mem_d_addr_i, mem_d_data_wr_i,
    input  mem_d_rd_i, mem_d_wr_i,
    input  mem_d_cacheable_i, mem_d_req_tag_i,
    input  mem_d_invalidate_i,
    input  mem_d_writeback_i, mem_d_flush_i,
    output mem_d_accept_o, mem_d_ack_o,
    output mem_d_error_o, mem_d_resp_tag_o,
    output mem_d_data_rd_o
  );

endinterface

// File: rtl/riscv_dmem_resp_pipe.sv
// Fixed-latency response delay line: valid_i/entry_i in,
// ack_o plus held tag_o/data_o and ack-qualified err_o out.
module riscv_dmem_resp_pipe
  import riscv_dmem_responder_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  resp_t             entry_i,
  output logic              ack_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  logic [LATENCY-1:0] vld_q;
  resp_t              stg_q [LATENCY];

  // Payload only moves with a valid bit, so the last
  // stage keeps the previous response between acks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) begin
        stg_q[0] <= entry_i;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          stg_q[i] <= stg_q[i-1];
        end
      end
    end
  end

  assign ack_o  = vld_q[LATENCY-1];
  assign tag_o  = stg_q[LATENCY-1].tag;
  assign data_o = stg_q[LATENCY-1].data;
  assign err_o  = vld_q[LATENCY-1] & stg_q[LATENCY-1].err;

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory model on the core mem_d_* port (dmem slave):
// word RAM, window decode, in-order fixed-latency tagged acks.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
  parameter int          MEM_WORDS    = 1024,
  parameter int          LATENCY      = 2,
  parameter int          MAX_OUTSTAND = 4,
  parameter int          ACCEPT_GAP   = 0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  riscv_dmem_responder_if.slave dmem
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int OUT_W = $clog2(MAX_OUTSTAND + 1);
  localparam int GAP_W =
    (ACCEPT_GAP > 0) ? $clog2(ACCEPT_GAP + 1) : 1;
  localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [32:0] WIN_HI =
    WIN_LO + (33'(MEM_WORDS) << 2);
  localparam logic [OUT_W-1:0] OUT_MAX =
    OUT_W'(MAX_OUTSTAND);
  localparam logic [GAP_W-1:0] GAP_LD =
    GAP_W'(ACCEPT_GAP);

  logic [31:0]      ram_q [MEM_WORDS];
  acc_state_e       state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  req_kind_e        kind;
  logic             fire;
  logic             hit;
  logic             ack;
  logic [32:0]      addr_x;
  logic [31:0]      offs;
  logic [IDX_W-1:0] idx;
  resp_t            entry;
  logic             unused_ok;

  assign kind = req_kind(
    dmem.mem_d_rd_i,
    dmem.mem_d_wr_i,
    dmem.mem_d_invalidate_i |
    dmem.mem_d_writeback_i |
    dmem.mem_d_flush_i
  );

  assign dmem.mem_d_accept_o =
    rst_i && (state_q == ACC_READY);
  assign fire =
    (kind != REQ_NONE) && dmem.mem_d_accept_o;

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  assign addr_x = {1'b0, dmem.mem_d_addr_i};
  assign hit    = (addr_x >= WIN_LO) && (addr_x < WIN_HI);
  assign offs   = dmem.mem_d_addr_i - MEM_BASE;
  assign idx    = offs[IDX_W+1:2];

  assign unused_ok = ^{dmem.mem_d_cacheable_i,
                       offs[1:0], offs[31:IDX_W+2]};

  // Read happens before this cycle's store lands.
  always_comb begin
    entry     = '0;
    entry.tag = dmem.mem_d_req_tag_i;
    unique case (kind)
      REQ_MEM: begin
        entry.err = !hit;
        if (dmem.mem_d_rd_i && hit) begin
          entry.data = ram_q[idx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (fire && (kind == REQ_MEM) && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem.mem_d_wr_i[b]) begin
          ram_q[idx][8*b +: 8] <=
            dmem.mem_d_data_wr_i[8*b +: 8];
        end
      end
    end
  end

  // State is a function of next counters so it never
  // disagrees with them.
  always_comb begin
    out_d   = out_q;
    gap_d   = gap_q;
    state_d = ACC_READY;
    if (fire && !ack) begin
      out_d = out_q + 1'b1;
    end else if (!fire && ack) begin
      out_d = out_q - 1'b1;
    end
    if (fire) begin
      gap_d = GAP_LD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
    unique case (1'b1)
      out_d == OUT_MAX:                   state_d = ACC_FULL;
      out_d != OUT_MAX && gap_d != '0:    state_d = ACC_GAP;
      default:                            state_d = ACC_READY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ACC_READY;
      out_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      gap_q   <= gap_d;
    end
  end

  riscv_dmem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (fire),
    .entry_i (entry),
    .ack_o   (ack),
    .tag_o   (dmem.mem_d_resp_tag_o),
    .data_o  (dmem.mem_d_data_rd_o),
    .err_o   (dmem.mem_d_error_o)
  );

  assign dmem.mem_d_ack_o = ack;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench: three responders (base, deep, gapped)
// sharing clock/reset; ack scoreboard per instance.
module tb_riscv_dmem_responder;

  localparam int LAT_T [3] = '{2, 8, 2};
  localparam int GAP_T [3] = '{0, 0, 2};

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  wr;
    logic        inv;
    logic        wb;
    logic        fl;
    logic [10:0] tag;
  } drv_t;

  typedef struct {
    int          cyc;
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  drv_t        drv [3];
  exp_t        exp_q [3][$];
  logic        acc [3];
  logic        ack [3];
  logic        err [3];
  logic [10:0] rtag [3];
  logic [31:0] rdat [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_dmem_responder_if u_if ();
    riscv_dmem_responder #(
      .MEM_BASE     (32'h8000_0000),
      .MEM_WORDS    (1024),
      .LATENCY      (LAT_T[g]),
      .MAX_OUTSTAND (4),
      .ACCEPT_GAP   (GAP_T[g])
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .dmem  (u_if)
    );
    assign u_if.mem_d_addr_i       = drv[g].addr;
    assign u_if.mem_d_data_wr_i    = drv[g].wdata;
    assign u_if.mem_d_rd_i         = drv[g].rd;
    assign u_if.mem_d_wr_i         = drv[g].wr;
    assign u_if.mem_d_cacheable_i  = 1'b1;
    assign u_if.mem_d_req_tag_i    = drv[g].tag;
    assign u_if.mem_d_invalidate_i = drv[g].inv;
    assign u_if.mem_d_writeback_i  = drv[g].wb;
    assign u_if.mem_d_flush_i      = drv[g].fl;
    assign acc[g]  = u_if.mem_d_accept_o;
    assign ack[g]  = u_if.mem_d_ack_o;
    assign err[g]  = u_if.mem_d_error_o;
    assign rtag[g] = u_if.mem_d_resp_tag_o;
    assign rdat[g] = u_if.mem_d_data_rd_o;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, got, want, cyc);
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    if (ack[k]) begin
      if (exp_q[k].size() == 0) begin
        chk($sformatf("ack_unexp%0d", k), ack[k], 0);
      end else begin
        e = exp_q[k].pop_front();
        chk($sformatf("ack_cyc%0d", k), cyc, e.cyc);
        chk($sformatf("ack_tag%0d", k), rtag[k], e.tag);
        chk($sformatf("ack_data%0d", k), rdat[k], e.data);
        chk($sformatf("ack_err%0d", k), err[k], e.err);
      end
    end else begin
      chk($sformatf("err_idle%0d", k), err[k], 0);
      if (exp_q[k].size() != 0 && exp_q[k][0].cyc <= cyc) begin
        chk($sformatf("ack_miss%0d", k), ack[k], 1);
        void'(exp_q[k].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) mon(k);
    end
  end

  // Issue one request at this negedge, expect it taken at
  // the next edge and acked LAT cycles later.
  task automatic req(input int k,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic rd,
                     input logic [3:0] wr,
                     input logic [2:0] cmo,
                     input logic [10:0] tag,
                     input logic [31:0] ed,
                     input logic ee);
    drv[k] = '{addr: a, wdata: wd, rd: rd, wr: wr,
               inv: cmo[2], wb: cmo[1], fl: cmo[0],
               tag: tag};
    chk($sformatf("accept%0d", k), acc[k], 1);
    exp_q[k].push_back('{cyc: cyc + LAT_T[k], tag: tag,
                         data: ed, err: ee});
    @(negedge clk);
    drv[k] = '0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) drv[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_accept", acc[k], 0);
      chk("rst_ack", ack[k], 0);
      chk("rst_err", err[k], 0);
      chk("rst_tag", rtag[k], 0);
      chk("rst_data", rdat[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // store then load same word
    req(0, 32'h8000_0004, 32'hA5A5_A5A5, 0, 4'hF, 3'b000,
        5, 0, 0);
    req(0, 32'h8000_0004, 0, 1, 4'h0, 3'b000,
        6, 32'hA5A5_A5A5, 0);
    repeat (2) @(negedge clk);
    chk("hold_ack", ack[0], 0);
    chk("hold_tag", rtag[0], 6);
    chk("hold_data", rdat[0], 32'hA5A5_A5A5);

    // window edges; miss below base must not alias top word
    req(0, 32'h8000_0FFC, 32'hCAFE_F00D, 0, 4'hF, 3'b000,
        1, 0, 0);
    req(0, 32'h7FFF_FFFC, 32'h5A5A_5A5A, 0, 4'hF, 3'b000,
        7, 0, 1);
    req(0, 32'h7FFF_FFFC, 0, 1, 4'h0, 3'b000, 8, 0, 1);
    req(0, 32'h8000_0FFC, 0, 1, 4'h0, 3'b000,
        9, 32'hCAFE_F00D, 0);
    req(0, 32'h8000_1000, 0, 1, 4'h0, 3'b000, 10, 0, 1);

    // partial store, then rd+wr in one request
    req(0, 32'h8000_0010, 32'h1122_3344, 0, 4'hF, 3'b000,
        11, 0, 0);
    req(0, 32'h8000_0010, 32'h0000_BB00, 0, 4'b0010, 3'b000,
        12, 0, 0);
    req(0, 32'h8000_0010, 0, 1, 4'h0, 3'b000,
        13, 32'h1122_BB44, 0);
    req(0, 32'h8000_0010, 32'hDEAD_BEEF, 1, 4'hF, 3'b000,
        14, 32'h1122_BB44, 0);
    req(0, 32'h8000_0010, 0, 1, 4'h0, 3'b000,
        15, 32'hDEAD_BEEF, 0);

    // cache ops: no error even off-window, no RAM effect
    req(0, 32'h0000_0000, 0, 0, 4'h0, 3'b100, 16, 0, 0);
    req(0, 32'h8000_0010, 0, 0, 4'h0, 3'b010, 17, 0, 0);
    req(0, 32'h8000_0010, 0, 1, 4'h0, 3'b000,
        18, 32'hDEAD_BEEF, 0);
    repeat (4) @(negedge clk);

    // outstanding limit on the deep instance
    req(1, 32'h8000_0020, 32'h0BAD_CAFE, 0, 4'hF, 3'b000,
        100, 0, 0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req(1, 32'h8000_0020, 0, 1, 4'h0, 3'b000,
          11'(i), 32'h0BAD_CAFE, 0);
    end
    drv[1] = '{addr: 32'h8000_0020, wdata: 0, rd: 1'b1,
               wr: 4'h0, inv: 1'b0, wb: 1'b0, fl: 1'b0,
               tag: 11'd4};
    repeat (5) begin
      chk("full_accept", acc[1], 0);
      @(negedge clk);
    end
    req(1, 32'h8000_0020, 0, 1, 4'h0, 3'b000,
        4, 32'h0BAD_CAFE, 0);
    repeat (9) @(negedge clk);

    // accept gap of 2 on the third instance
    req(2, 32'h0000_0000, 0, 0, 4'h0, 3'b001, 30, 0, 0);
    drv[2] = '{addr: 0, wdata: 0, rd: 1'b0, wr: 4'h0,
               inv: 1'b1, wb: 1'b0, fl: 1'b0, tag: 11'd31};
    repeat (2) begin
      chk("gap_accept", acc[2], 0);
      @(negedge clk);
    end
    req(2, 32'h0000_0000, 0, 0, 4'h0, 3'b100, 31, 0, 0);
    drv[2] = '{addr: 32'h8000_0000, wdata: 0, rd: 1'b0,
               wr: 4'h0, inv: 1'b0, wb: 1'b1, fl: 1'b0,
               tag: 11'd32};
    repeat (2) begin
      chk("gap_accept", acc[2], 0);
      @(negedge clk);
    end
    req(2, 32'h8000_0000, 0, 0, 4'h0, 3'b010, 32, 0, 0);
    repeat (4) @(negedge clk);

    // reset with three responses in flight
    req(1, 32'h8000_0020, 0, 1, 4'h0, 3'b000,
        40, 32'h0BAD_CAFE, 0);
    req(1, 32'h8000_0020, 0, 1, 4'h0, 3'b000,
        41, 32'h0BAD_CAFE, 0);
    req(1, 32'h8000_0020, 0, 1, 4'h0, 3'b000,
        42, 32'h0BAD_CAFE, 0);
    #2 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    @(negedge clk);
    chk("rst2_accept", acc[1], 0);
    chk("rst2_ack", ack[1], 0);
    chk("rst2_tag", rtag[1], 0);
    chk("rst2_data", rdat[1], 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_accept", acc[1], 1);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain%0d", k), exp_q[k].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
